writeback_top: RTL and testbench
================================

// Module: writeback_top
// PURPOSE
//  Final pipeline stage; consumer end of the execute->writeback valid/ready pipestage. Takes one
//  retired op per handshake and commits it: register-file write, or memory write split into
//  32-bit beats (aligned or unaligned). Issues the front-end redirect/flush on branch
//  misprediction or far jump, and a sys-controller handoff when the op requests one.
// PARAMETERS
//  MAX_BEATS  3  max memory beats per op (8 bytes at byte offset 3 -> 3 beats)
//  REG_IDX_W  3  register index width taken from wb_dest_reg[REG_IDX_W-1:0]
// PORTS
//  clk                   in   1   clock
//  reset                 in   1   asynchronous, active-high
//  wb_valid              in   1   execute has an op
//  wb_ready              out  1   writeback can accept; equals (state==IDLE)
//  wb_dest_address       in   32  memory byte address
//  wb_dest_reg           in   32  register index (low REG_IDX_W bits used)
//  wb_result             in   64  data to commit / redirect target in [31:0]
//  wb_opsize             in   2   0=8b 1=16b 2=32b 3=64b
//  wb_mem_or_reg         in   1   1=memory write, 0=register write
//  wb_to_sys_controller  in   1   op needs sys-controller handoff after commit
//  wb_pc                 in   32  EIP of op
//  wb_jump_load_address  in   1   far/indirect jump: redirect to wb_result[31:0]
//  wb_jump_load_cs       in   1   redirect also loads CS
//  wb_cs_out             in   32  new CS (low 16 bits used)
//  wb_br_misprediction   in   1   redirect to wb_result[31:0]
//  rf_we / rf_idx / rf_data / rf_size  out 1/3/64/2  register-file write port
//  mem_req_valid         out  1   memory write beat valid
//  mem_req_ready         in   1   memory accepts beat
//  mem_addr / mem_data / mem_be  out 32/32/4  word-aligned address, data, byte enables
//  redirect_valid        out  1   one-cycle redirect pulse
//  redirect_eip / redirect_cs / redirect_load_cs  out 32/16/1
//  flush_out             out  1   one-cycle pipeline flush, coincident with redirect_valid
//  sys_valid / sys_ready / sys_pc  out/in/out 1/1/32  sys-controller handshake
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0 except wb_ready=1; holding register cleared.
//  - Accept when wb_valid&wb_ready (cycle T): all wb_* inputs captured in holding register.
//  - FSM: IDLE -> REG (mem_or_reg=0) | MEM (mem_or_reg=1); REG/MEM -> SYS if to_sys_controller
//    else IDLE; SYS -> IDLE on sys_ready.
//  - REG: rf_we=1 for exactly cycle T+1; rf_data=result, rf_size=opsize. Min throughput 1 op/2 cycles.
//  - MEM: bytes=1<<opsize; off=addr[1:0]; beats=ceil((off+bytes)/4) in 1..3.
//    shifted[95:0]={32'b0,result}<<(8*off); bemask[11:0]=((1<<bytes)-1)<<off.
//    beat k: mem_addr={addr[31:2],2'b0}+4k, mem_data=shifted[32k+:32], mem_be=bemask[4k+:4].
//    mem_req_valid from T+1; beat advances only on mem_req_valid&mem_req_ready; outputs stable
//    while stalled; address wraps mod 2^32; leaves MEM the cycle after last beat handshake.
//  - Redirect: if br_misprediction|jump_load_address, redirect_valid=flush_out=1 in the single
//    cycle leaving REG/MEM (after the commit completes); redirect_eip=result[31:0],
//    redirect_cs=cs_out[15:0], redirect_load_cs=jump_load_cs. Misprediction with no write
//    still passes through REG (rf_we suppressed when dest idx unused is not decoded; always writes).
//  - SYS: sys_valid held with sys_pc=pc until sys_ready; redirect, if any, fires before SYS.
//  - A captured op always completes; upstream flush never cancels it. reset mid-MEM/SYS drops
//    remaining beats immediately (async), mem_req_valid/sys_valid fall to 0 same instant.
// STRUCTURE
//  - writeback_pkg: opsize encodings, FSM state encodings, MAX_BEATS, beat-count function.
//  - Sub-module wb_mem_splitter: combinational addr/opsize/result -> beat count, per-beat
//    addr/data/be; top holds FSM, holding register, beat counter, handshakes.
// TESTING
//  1 Reg: dest_reg=3, result=0x12345678, opsize=2 -> rf_we@T+1 idx=3 data=0x12345678; wb_ready=1@T+2.
//  2 Mem64 aligned: addr=0x1000, result=0x1122334455667788 -> (0x1000,0x55667788,F),(0x1004,0x11223344,F).
//  3 Mem32 unaligned: addr=0x1003, result=0xAABBCCDD -> (0x1000,0xDD000000,8),(0x1004,0x00AABBCC,7).
//  4 Backpressure: mem_req_ready=0 for 5 cycles on beat0 -> addr/data/be unchanged, wb_ready=0 throughout.
//  5 Mispredict: br_misprediction=1, result=0x2000, cs_out=0x8, jump_load_cs=1 -> one-cycle
//    redirect_valid=flush_out=1, eip=0x2000, cs=0x8, load_cs=1.
//  6 reset asserted during beat1 of test 2 -> mem_req_valid=0 immediately; after release wb_ready=1, no beat.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared encodings for the writeback stage: operand sizes, FSM states and the
// beat-count helper used to split memory writes into 32-bit beats.
package writeback_pkg;

    typedef enum logic [1:0] {
        OP_8  = 2'd0,
        OP_16 = 2'd1,
        OP_32 = 2'd2,
        OP_64 = 2'd3
    } wb_opsize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REG  = 2'd1,
        ST_MEM  = 2'd2,
        ST_SYS  = 2'd3
    } wb_state_e;

    localparam int WB_MAX_BEATS = 3;
    localparam int WB_BEAT_W    = 2;

    // ceil((off + bytes) / 4); the largest span is 3 + 8 = 11 bytes -> 3 beats.
    function automatic logic [1:0] wb_beat_count(input logic [1:0] off, input logic [1:0] opsize);
        logic [3:0] span;
        span = {2'b00, off} + (4'd1 << opsize) + 4'd3;
        return span[3:2];
    endfunction

endpackage

// File: rtl/wb_mem_splitter.sv
// Combinational split of one memory write into word-aligned 32-bit beats:
// beat count plus the address, data and byte enables of the selected beat.
module wb_mem_splitter
    import writeback_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_opsize,
    input  logic [63:0] i_result,
    input  logic [1:0]  i_beat,
    output logic [1:0]  o_beats,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic [3:0]  o_be
);

    logic [11:0] w_bytes_mask;
    logic [11:0] w_bemask;
    logic [95:0] w_shifted;

    always_comb begin
        case (wb_opsize_e'(i_opsize))
            OP_8:    w_bytes_mask = 12'h001;
            OP_16:   w_bytes_mask = 12'h003;
            OP_32:   w_bytes_mask = 12'h00F;
            default: w_bytes_mask = 12'h0FF;
        endcase
    end

    assign w_shifted = {32'd0, i_result} << {i_addr[1:0], 3'b000};
    assign w_bemask  = w_bytes_mask << i_addr[1:0];
    assign o_beats   = wb_beat_count(i_addr[1:0], i_opsize);
    // Beat addresses wrap naturally modulo 2^32.
    assign o_addr    = {i_addr[31:2], 2'b00} + {28'd0, i_beat, 2'b00};

    always_comb begin
        case (i_beat)
            2'd0: begin
                o_data = w_shifted[31:0];
                o_be   = w_bemask[3:0];
            end
            2'd1: begin
                o_data = w_shifted[63:32];
                o_be   = w_bemask[7:4];
            end
            default: begin
                o_data = w_shifted[95:64];
                o_be   = w_bemask[11:8];
            end
        endcase
    end

endmodule

// File: rtl/writeback_top.sv
// Writeback stage: accepts one retired op per handshake, commits it to the
// register file or as memory beats, then issues redirect/flush and sys handoff.
module writeback_top
    import writeback_pkg::*;
#(
    parameter int MAX_BEATS = WB_MAX_BEATS,
    parameter int REG_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [31:0]          wb_dest_address,
    input  logic [31:0]          wb_dest_reg,
    input  logic [63:0]          wb_result,
    input  logic [1:0]           wb_opsize,
    input  logic                 wb_mem_or_reg,
    input  logic                 wb_to_sys_controller,
    input  logic [31:0]          wb_pc,
    input  logic                 wb_jump_load_address,
    input  logic                 wb_jump_load_cs,
    input  logic [31:0]          wb_cs_out,
    input  logic                 wb_br_misprediction,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_idx,
    output logic [63:0]          rf_data,
    output logic [1:0]           rf_size,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_data,
    output logic [3:0]           mem_be,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_eip,
    output logic [15:0]          redirect_cs,
    output logic                 redirect_load_cs,
    output logic                 flush_out,
    output logic                 sys_valid,
    input  logic                 sys_ready,
    output logic [31:0]          sys_pc
);

    localparam logic [WB_BEAT_W-1:0] LAST_BEAT_CAP = WB_BEAT_W'(MAX_BEATS - 1);

    wb_state_e              r_state;
    logic [WB_BEAT_W-1:0]   r_beat;
    logic [31:0]            r_addr;
    logic [REG_IDX_W-1:0]   r_dest;
    logic [63:0]            r_result;
    logic [1:0]             r_opsize;
    logic                   r_to_sys;
    logic [31:0]            r_pc;
    logic                   r_jump_ld;
    logic                   r_jump_cs;
    logic [15:0]            r_cs;
    logic                   r_br_mis;

    logic [1:0]             w_beats;
    logic [31:0]            w_beat_addr;
    logic [31:0]            w_beat_data;
    logic [3:0]             w_beat_be;
    logic                   w_in_mem;
    logic                   w_last_beat;
    logic                   w_leave;
    logic                   w_unused;

    wb_mem_splitter u_splitter (
        .i_addr   (r_addr),
        .i_opsize (r_opsize),
        .i_result (r_result),
        .i_beat   (r_beat),
        .o_beats  (w_beats),
        .o_addr   (w_beat_addr),
        .o_data   (w_beat_data),
        .o_be     (w_beat_be)
    );

    assign w_unused    = &{1'b0, wb_dest_reg[31:REG_IDX_W], wb_cs_out[31:16]};
    assign w_in_mem    = (r_state == ST_MEM);
    assign w_last_beat = (r_beat == w_beats - 2'd1) || (r_beat == LAST_BEAT_CAP);
    // Commit finishes on this cycle's edge: the REG cycle, or the final beat handshake.
    assign w_leave     = (r_state == ST_REG) || (w_in_mem && mem_req_ready && w_last_beat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_addr    <= '0;
            r_dest    <= '0;
            r_result  <= '0;
            r_opsize  <= '0;
            r_to_sys  <= 1'b0;
            r_pc      <= '0;
            r_jump_ld <= 1'b0;
            r_jump_cs <= 1'b0;
            r_cs      <= '0;
            r_br_mis  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (wb_valid) begin
                        r_addr    <= wb_dest_address;
                        r_dest    <= wb_dest_reg[REG_IDX_W-1:0];
                        r_result  <= wb_result;
                        r_opsize  <= wb_opsize;
                        r_to_sys  <= wb_to_sys_controller;
                        r_pc      <= wb_pc;
                        r_jump_ld <= wb_jump_load_address;
                        r_jump_cs <= wb_jump_load_cs;
                        r_cs      <= wb_cs_out[15:0];
                        r_br_mis  <= wb_br_misprediction;
                        r_beat    <= '0;
                        r_state   <= wb_mem_or_reg ? ST_MEM : ST_REG;
                    end
                end
                ST_REG: begin
                    r_state <= r_to_sys ? ST_SYS : ST_IDLE;
                end
                ST_MEM: begin
                    if (mem_req_ready) begin
                        if (w_last_beat) begin
                            r_state <= r_to_sys ? ST_SYS : ST_IDLE;
                        end else begin
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                end
                ST_SYS: begin
                    if (sys_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wb_ready         = (r_state == ST_IDLE);
    assign rf_we            = (r_state == ST_REG);
    assign rf_idx           = r_dest;
    assign rf_data          = r_result;
    assign rf_size          = r_opsize;

    assign mem_req_valid    = w_in_mem;
    assign mem_addr         = w_in_mem ? w_beat_addr : 32'd0;
    assign mem_data         = w_in_mem ? w_beat_data : 32'd0;
    assign mem_be           = w_in_mem ? w_beat_be   : 4'd0;

    assign redirect_valid   = w_leave && (r_br_mis || r_jump_ld);
    assign flush_out        = redirect_valid;
    assign redirect_eip     = r_result[31:0];
    assign redirect_cs      = r_cs;
    assign redirect_load_cs = r_jump_cs;

    assign sys_valid        = (r_state == ST_SYS);
    assign sys_pc           = r_pc;

endmodule

// File: tb/tb_writeback_top.sv
// Directed-vector bench for writeback_top: register commits, aligned/unaligned
// and wrapping memory beats, backpressure, redirects, sys handoff, async reset.
module tb_writeback_top;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [31:0] wb_dest_address = '0;
    logic [31:0] wb_dest_reg = '0;
    logic [63:0] wb_result = '0;
    logic [1:0]  wb_opsize = '0;
    logic        wb_mem_or_reg = 1'b0;
    logic        wb_to_sys_controller = 1'b0;
    logic [31:0] wb_pc = '0;
    logic        wb_jump_load_address = 1'b0;
    logic        wb_jump_load_cs = 1'b0;
    logic [31:0] wb_cs_out = '0;
    logic        wb_br_misprediction = 1'b0;
    logic        rf_we;
    logic [2:0]  rf_idx;
    logic [63:0] rf_data;
    logic [1:0]  rf_size;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic        redirect_valid;
    logic [31:0] redirect_eip;
    logic [15:0] redirect_cs;
    logic        redirect_load_cs;
    logic        flush_out;
    logic        sys_valid;
    logic        sys_ready = 1'b0;
    logic [31:0] sys_pc;

    int n_total = 0;
    int n_bad   = 0;

    writeback_top dut (
        .clk                  (clk),
        .reset                (reset),
        .wb_valid             (wb_valid),
        .wb_ready             (wb_ready),
        .wb_dest_address      (wb_dest_address),
        .wb_dest_reg          (wb_dest_reg),
        .wb_result            (wb_result),
        .wb_opsize            (wb_opsize),
        .wb_mem_or_reg        (wb_mem_or_reg),
        .wb_to_sys_controller (wb_to_sys_controller),
        .wb_pc                (wb_pc),
        .wb_jump_load_address (wb_jump_load_address),
        .wb_jump_load_cs      (wb_jump_load_cs),
        .wb_cs_out            (wb_cs_out),
        .wb_br_misprediction  (wb_br_misprediction),
        .rf_we                (rf_we),
        .rf_idx               (rf_idx),
        .rf_data              (rf_data),
        .rf_size              (rf_size),
        .mem_req_valid        (mem_req_valid),
        .mem_req_ready        (mem_req_ready),
        .mem_addr             (mem_addr),
        .mem_data             (mem_data),
        .mem_be               (mem_be),
        .redirect_valid       (redirect_valid),
        .redirect_eip         (redirect_eip),
        .redirect_cs          (redirect_cs),
        .redirect_load_cs     (redirect_load_cs),
        .flush_out            (flush_out),
        .sys_valid            (sys_valid),
        .sys_ready            (sys_ready),
        .sys_pc               (sys_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d", n_total);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] dest, input logic [63:0] result,
                         input logic [1:0] opsize, input logic mem, input logic to_sys,
                         input logic [31:0] pc, input logic jla, input logic jlcs,
                         input logic [31:0] cs, input logic brm);
        wb_dest_address      = addr;
        wb_dest_reg          = dest;
        wb_result            = result;
        wb_opsize            = opsize;
        wb_mem_or_reg        = mem;
        wb_to_sys_controller = to_sys;
        wb_pc                = pc;
        wb_jump_load_address = jla;
        wb_jump_load_cs      = jlcs;
        wb_cs_out            = cs;
        wb_br_misprediction  = brm;
        wb_valid             = 1'b1;
        tick();
        wb_valid             = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        check_eq({tag, ".valid"}, mem_req_valid, 1'b1);
        check_eq({tag, ".addr"},  mem_addr, a);
        check_eq({tag, ".data"},  mem_data, d);
        check_eq({tag, ".be"},    mem_be, be);
    endtask

    initial begin
        #2 reset = 1'b1;
        tick();
        tick();
        check_eq("rst.wb_ready", wb_ready, 1'b1);
        check_eq("rst.rf_we", rf_we, 1'b0);
        check_eq("rst.mem_valid", mem_req_valid, 1'b0);
        check_eq("rst.mem_be", mem_be, 4'h0);
        check_eq("rst.redirect", redirect_valid, 1'b0);
        check_eq("rst.sys_valid", sys_valid, 1'b0);
        reset = 1'b0;
        tick();

        // Register write
        check_eq("reg.ready_T", wb_ready, 1'b1);
        issue(32'h0, 32'd3, 64'h12345678, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("reg.rf_we", rf_we, 1'b1);
        check_eq("reg.rf_idx", rf_idx, 3'd3);
        check_eq("reg.rf_data", rf_data, 64'h12345678);
        check_eq("reg.rf_size", rf_size, 2'd2);
        check_eq("reg.busy", wb_ready, 1'b0);
        check_eq("reg.no_redirect", redirect_valid, 1'b0);
        tick();
        check_eq("reg.rf_we_off", rf_we, 1'b0);
        check_eq("reg.ready_T2", wb_ready, 1'b1);

        // 64-bit aligned memory write
        issue(32'h1000, 32'd0, 64'h1122334455667788, 2'd3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_beat("m64.b0", 32'h1000, 32'h55667788, 4'hF);
        check_eq("m64.rf_we", rf_we, 1'b0);
        tick();
        check_beat("m64.b1", 32'h1004, 32'h11223344, 4'hF);
        tick();
        check_eq("m64.done_valid", mem_req_valid, 1'b0);
        check_eq("m64.done_ready", wb_ready, 1'b1);

        // 32-bit unaligned memory write
        issue(32'h1003, 32'd0, 64'hAABBCCDD, 2'd2, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_beat("m32u.b0", 32'h1000, 32'hDD000000, 4'h8);
        tick();
        check_beat("m32u.b1", 32'h1004, 32'h00AABBCC, 4'h7);
        tick();
        check_eq("m32u.done", wb_ready, 1'b1);

        // 64-bit at offset 3: three beats
        issue(32'h3003, 32'd0, 64'h0102030405060708, 2'd3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_beat("m3.b0", 32'h3000, 32'h08000000, 4'h8);
        tick();
        check_beat("m3.b1", 32'h3004, 32'h04050607, 4'hF);
        tick();
        check_beat("m3.b2", 32'h3008, 32'h00010203, 4'h7);
        tick();
        check_eq("m3.done", wb_ready, 1'b1);

        // Address wrap across 2^32
        issue(32'hFFFF_FFFE, 32'd0, 64'h11223344, 2'd2, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_beat("wrap.b0", 32'hFFFF_FFFC, 32'h33440000, 4'hC);
        tick();
        check_beat("wrap.b1", 32'h0000_0000, 32'h00001122, 4'h3);
        tick();
        check_eq("wrap.done", wb_ready, 1'b1);

        // Backpressure on a single-beat 16-bit write at offset 1
        mem_req_ready = 1'b0;
        issue(32'h2001, 32'd0, 64'hBEEF, 2'd1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_beat("bp.stall", 32'h2000, 32'h00BEEF00, 4'h6);
            check_eq("bp.busy", wb_ready, 1'b0);
            tick();
        end
        mem_req_ready = 1'b1;
        check_beat("bp.release", 32'h2000, 32'h00BEEF00, 4'h6);
        tick();
        check_eq("bp.done_valid", mem_req_valid, 1'b0);
        check_eq("bp.done_ready", wb_ready, 1'b1);

        // Misprediction on a register op
        issue(32'h0, 32'd5, 64'h2000, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b1);
        check_eq("mis.rf_we", rf_we, 1'b1);
        check_eq("mis.redirect", redirect_valid, 1'b1);
        check_eq("mis.flush", flush_out, 1'b1);
        check_eq("mis.eip", redirect_eip, 32'h2000);
        check_eq("mis.cs", redirect_cs, 16'h8);
        check_eq("mis.load_cs", redirect_load_cs, 1'b1);
        tick();
        check_eq("mis.redirect_off", redirect_valid, 1'b0);
        check_eq("mis.flush_off", flush_out, 1'b0);
        check_eq("mis.ready", wb_ready, 1'b1);

        // Far jump on a memory op: redirect only on the last-beat handshake
        mem_req_ready = 1'b0;
        issue(32'h4000, 32'd0, 64'h5000, 2'd2, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("mj.stall_redirect", redirect_valid, 1'b0);
        mem_req_ready = 1'b1;
        #1;
        check_eq("mj.redirect", redirect_valid, 1'b1);
        check_eq("mj.eip", redirect_eip, 32'h5000);
        check_eq("mj.load_cs", redirect_load_cs, 1'b0);
        tick();
        check_eq("mj.redirect_off", redirect_valid, 1'b0);

        // Jump with sys handoff: redirect first, then sys handshake
        issue(32'h0, 32'd1, 64'h7000, 2'd2, 1'b0, 1'b1, 32'hCAFE0000, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("sys.redirect", redirect_valid, 1'b1);
        check_eq("sys.not_yet", sys_valid, 1'b0);
        tick();
        check_eq("sys.valid", sys_valid, 1'b1);
        check_eq("sys.pc", sys_pc, 32'hCAFE0000);
        check_eq("sys.redirect_off", redirect_valid, 1'b0);
        tick();
        check_eq("sys.held", sys_valid, 1'b1);
        check_eq("sys.busy", wb_ready, 1'b0);
        sys_ready = 1'b1;
        tick();
        sys_ready = 1'b0;
        check_eq("sys.done_valid", sys_valid, 1'b0);
        check_eq("sys.done_ready", wb_ready, 1'b1);

        // Async reset during beat 1 of the aligned 64-bit write
        issue(32'h1000, 32'd0, 64'h1122334455667788, 2'd3, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        mem_req_ready = 1'b0;
        check_beat("rmid.b1", 32'h1004, 32'h11223344, 4'hF);
        #2 reset = 1'b1;
        #1;
        check_eq("rmid.valid_drop", mem_req_valid, 1'b0);
        check_eq("rmid.ready", wb_ready, 1'b1);
        tick();
        reset = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        check_eq("rmid.after_ready", wb_ready, 1'b1);
        check_eq("rmid.after_valid", mem_req_valid, 1'b0);
        tick();
        check_eq("rmid.no_beat", mem_req_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
